fpu_arb: RTL and testbench

FPU_ARB -- requirements
Module: fpu_arb

---
 rtl/fpu_arb_if.sv | 83 ++++++++
 rtl/fpu_arb.sv | 187 ++++++++++++++++++
 tb/tb_fpu_arb.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_arb_if.sv
// fpu_arb_if: requester, response and FPU-side signals of the two-port FPU arbiter.
// The sticky flag ports exist only when FPU_ARB_STICKY_EN is defined.
interface fpu_arb_if;
  localparam int unsigned OP_W = 3;
  localparam int unsigned RM_W = 2;
  localparam int unsigned D_W  = 32;
  localparam int unsigned FL_W = 8;

  logic            req0_valid;
  logic            req0_ready;
  logic [OP_W-1:0] req0_op;
  logic [RM_W-1:0] req0_rmode;
  logic [D_W-1:0]  req0_opa;
  logic [D_W-1:0]  req0_opb;

  logic            req1_valid;
  logic            req1_ready;
  logic [OP_W-1:0] req1_op;
  logic [RM_W-1:0] req1_rmode;
  logic [D_W-1:0]  req1_opa;
  logic [D_W-1:0]  req1_opb;

  logic            rsp0_valid;
  logic [D_W-1:0]  rsp0_data;
  logic [FL_W-1:0] rsp0_flags;
  logic            rsp1_valid;
  logic [D_W-1:0]  rsp1_data;
  logic [FL_W-1:0] rsp1_flags;

  logic [OP_W-1:0] fpu_op;
  logic [RM_W-1:0] fpu_rmode;
  logic [D_W-1:0]  fpu_opa;
  logic [D_W-1:0]  fpu_opb;
  logic [D_W-1:0]  fpu_out;
  logic [FL_W-1:0] fpu_flags;

`ifdef FPU_ARB_STICKY_EN
  logic [FL_W-1:0] sticky0;
  logic            sticky0_clr;
  logic [FL_W-1:0] sticky1;
  logic            sticky1_clr;

  modport slave (
    input  req0_valid, req0_op, req0_rmode, req0_opa, req0_opb,
    input  req1_valid, req1_op, req1_rmode, req1_opa, req1_opb,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_flags, rsp1_valid, rsp1_data, rsp1_flags,
    output fpu_op, fpu_rmode, fpu_opa, fpu_opb,
    input  fpu_out, fpu_flags,
    output sticky0, sticky1,
    input  sticky0_clr, sticky1_clr
  );

  modport master (
    output req0_valid, req0_op, req0_rmode, req0_opa, req0_opb,
    output req1_valid, req1_op, req1_rmode, req1_opa, req1_opb,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_flags, rsp1_valid, rsp1_data, rsp1_flags,
    input  fpu_op, fpu_rmode, fpu_opa, fpu_opb,
    output fpu_out, fpu_flags,
    input  sticky0, sticky1,
    output sticky0_clr, sticky1_clr
  );
`else
  modport slave (
    input  req0_valid, req0_op, req0_rmode, req0_opa, req0_opb,
    input  req1_valid, req1_op, req1_rmode, req1_opa, req1_opb,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_flags, rsp1_valid, rsp1_data, rsp1_flags,
    output fpu_op, fpu_rmode, fpu_opa, fpu_opb,
    input  fpu_out, fpu_flags
  );

  modport master (
    output req0_valid, req0_op, req0_rmode, req0_opa, req0_opb,
    output req1_valid, req1_op, req1_rmode, req1_opa, req1_opb,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_flags, rsp1_valid, rsp1_data, rsp1_flags,
    input  fpu_op, fpu_rmode, fpu_opa, fpu_opb,
    output fpu_out, fpu_flags
  );
`endif
endinterface

// File: rtl/fpu_arb.sv
// fpu_arb: round-robin arbiter sharing one fixed-latency pipelined FPU between two requesters.
// Define FPU_ARB_STICKY_EN to add per-requester sticky exception-flag accumulators.
module fpu_arb #(
  parameter int unsigned LAT = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  output logic     idle,
  fpu_arb_if.slave bus
);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned RM_W  = 2;
  localparam int unsigned D_W   = 32;
  localparam int unsigned FL_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             ready0_c;
  logic             ready1_c;
  logic             acc0_c;
  logic             acc1_c;
  logic             acc_c;
  logic             rsp_fire_c;
  logic             rsp_tag_c;
  logic             last;
  logic [LAT-1:0]   sr_valid;
  logic [LAT-1:0]   sr_tag;
  logic [CNT_W-1:0] cnt;

  logic [OP_W-1:0]  op_q;
  logic [RM_W-1:0]  rm_q;
  logic [D_W-1:0]   opa_q;
  logic [D_W-1:0]   opb_q;
  logic             rsp0_valid_q;
  logic             rsp1_valid_q;
  logic [D_W-1:0]   rsp0_data_q;
  logic [D_W-1:0]   rsp1_data_q;
  logic [FL_W-1:0]  rsp0_flags_q;
  logic [FL_W-1:0]  rsp1_flags_q;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (en) state_nxt = S_RUN;
      S_RUN:   if (!en) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (en)               state_nxt = S_RUN;
        else if (cnt == '0)   state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // grant: a lone valid wins; on a tie the requester not served last wins
  always_comb begin
    ready0_c = 1'b0;
    ready1_c = 1'b0;
    if (state == S_RUN && en) begin
      if (bus.req0_valid && bus.req1_valid) begin
        ready0_c = last;
        ready1_c = !last;
      end else begin
        ready0_c = bus.req0_valid;
        ready1_c = bus.req1_valid;
      end
    end
  end

  assign acc0_c     = bus.req0_valid && ready0_c;
  assign acc1_c     = bus.req1_valid && ready1_c;
  assign acc_c      = acc0_c || acc1_c;
  assign rsp_fire_c = sr_valid[LAT-1];
  assign rsp_tag_c  = sr_tag[LAT-1];

  // last = 1 means requester 1 was served most recently, so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle     <= 1'b1;
      last     <= 1'b1;
      sr_valid <= '0;
      sr_tag   <= '0;
      cnt      <= '0;
    end else begin
      idle     <= (state_nxt == S_IDLE);
      sr_valid <= LAT'({sr_valid, acc_c});
      sr_tag   <= LAT'({sr_tag, acc1_c});
      if (acc_c) last <= acc1_c;
      unique case ({acc_c, rsp_fire_c})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // operand launch register, held until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      rm_q  <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else if (acc0_c) begin
      op_q  <= bus.req0_op;
      rm_q  <= bus.req0_rmode;
      opa_q <= bus.req0_opa;
      opb_q <= bus.req0_opb;
    end else if (acc1_c) begin
      op_q  <= bus.req1_op;
      rm_q  <= bus.req1_rmode;
      opa_q <= bus.req1_opa;
      opb_q <= bus.req1_opb;
    end
  end

  // response capture, steered by the tag leaving the shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      rsp0_flags_q <= '0;
      rsp1_flags_q <= '0;
    end else begin
      rsp0_valid_q <= rsp_fire_c && !rsp_tag_c;
      rsp1_valid_q <= rsp_fire_c && rsp_tag_c;
      if (rsp_fire_c && !rsp_tag_c) begin
        rsp0_data_q  <= bus.fpu_out;
        rsp0_flags_q <= bus.fpu_flags;
      end
      if (rsp_fire_c && rsp_tag_c) begin
        rsp1_data_q  <= bus.fpu_out;
        rsp1_flags_q <= bus.fpu_flags;
      end
    end
  end

`ifdef FPU_ARB_STICKY_EN
  logic [FL_W-1:0] sticky0_q;
  logic [FL_W-1:0] sticky1_q;

  // sticky accumulators; clear wins over a same-cycle response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky0_q <= '0;
      sticky1_q <= '0;
    end else begin
      if (bus.sticky0_clr)   sticky0_q <= '0;
      else if (rsp0_valid_q) sticky0_q <= sticky0_q | rsp0_flags_q;
      if (bus.sticky1_clr)   sticky1_q <= '0;
      else if (rsp1_valid_q) sticky1_q <= sticky1_q | rsp1_flags_q;
    end
  end

  assign bus.sticky0 = sticky0_q;
  assign bus.sticky1 = sticky1_q;
`endif

  assign bus.req0_ready = ready0_c;
  assign bus.req1_ready = ready1_c;
  assign bus.fpu_op     = op_q;
  assign bus.fpu_rmode  = rm_q;
  assign bus.fpu_opa    = opa_q;
  assign bus.fpu_opb    = opb_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_data  = rsp0_data_q;
  assign bus.rsp1_data  = rsp1_data_q;
  assign bus.rsp0_flags = rsp0_flags_q;
  assign bus.rsp1_flags = rsp1_flags_q;
endmodule

// File: tb/tb_fpu_arb.sv
// tb_fpu_arb: scoreboard bench for fpu_arb with a stand-in pipelined FPU.
// Define FPU_ARB_STICKY_EN for both RTL and bench to exercise the sticky flags.
module tb_fpu_arb;
  localparam int unsigned LAT = 4;
  localparam int unsigned TMO = 40;

  typedef struct {
    logic        tag;
    logic [31:0] data;
    logic [7:0]  flags;
    int          due;
  } exp_t;

  typedef enum logic [1:0] {M_IDLE, M_RUN, M_DRAIN} mstate_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic idle;

  fpu_arb_if bus();

  fpu_arb #(.LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .idle  (idle),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rsp_seen = 0;
  int acc_hist[$];
  exp_t q[$];

  mstate_t     m_state = M_IDLE;
  logic        m_last  = 1'b1;
  int          m_cnt   = 0;
  logic [31:0] m_d0, m_d1, m_a, m_b;
  logic [7:0]  m_f0, m_f1, m_s0, m_s1;
  logic [2:0]  m_op;
  logic [1:0]  m_rm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // stand-in FPU result: exact value for 1.0+2.0, otherwise an operand mix
  function automatic logic [31:0] fpu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    if (op == 3'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a ^ {b[15:0], b[31:16]} ^ {29'd0, op};
  endfunction

  logic [31:0] res_c;
  logic [31:0] pipe_d [LAT-1];
  logic [7:0]  pipe_f [LAT-1];

  always_comb res_c = fpu_model(bus.fpu_op, bus.fpu_opa, bus.fpu_opb);

  always @(posedge clk) begin
    pipe_d[0] <= res_c;
    pipe_f[0] <= bus.fpu_opb[7:0];
    for (int i = 1; i < int'(LAT) - 1; i++) begin
      pipe_d[i] <= pipe_d[i-1];
      pipe_f[i] <= pipe_f[i-1];
    end
  end

  assign bus.fpu_out   = pipe_d[LAT-2];
  assign bus.fpu_flags = pipe_f[LAT-2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic mon_step();
    logic       r0, r1, a0, a1, fire, pri;
    logic [7:0] set0, set1;
    exp_t       e;
    if (!rst_n) begin
      q.delete();
      m_state = M_IDLE; m_last = 1'b1; m_cnt = 0;
      m_d0 = '0; m_d1 = '0; m_f0 = '0; m_f1 = '0; m_s0 = '0; m_s1 = '0;
      m_op = '0; m_rm = '0; m_a = '0; m_b = '0;
      chk("rst_idle", 32'(idle), 32'd1);
      chk("rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      chk("rst_rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
      chk("rst_rsp_data", bus.rsp0_data | bus.rsp1_data, 32'd0);
      chk("rst_rsp_flags", 32'({bus.rsp1_flags, bus.rsp0_flags}), 32'd0);
      chk("rst_fpu", 32'({bus.fpu_op, bus.fpu_rmode}) | bus.fpu_opa | bus.fpu_opb, 32'd0);
`ifdef FPU_ARB_STICKY_EN
      chk("rst_sticky", 32'({bus.sticky1, bus.sticky0}), 32'd0);
`endif
      return;
    end
    set0 = '0;
    set1 = '0;
    chk("idle", 32'(idle), 32'(m_state == M_IDLE));
    if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), e.tag ? 32'd2 : 32'd1);
      if (e.tag) begin m_d1 = e.data; m_f1 = e.flags; set1 = e.flags; end
      else       begin m_d0 = e.data; m_f0 = e.flags; set0 = e.flags; end
      rsp_seen++;
    end else begin
      chk("rsp_quiet", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
    end
    chk("rsp0_data", bus.rsp0_data, m_d0);
    chk("rsp1_data", bus.rsp1_data, m_d1);
    chk("rsp_flags", 32'({bus.rsp1_flags, bus.rsp0_flags}), 32'({m_f1, m_f0}));
    chk("fpu_op_rm", 32'({bus.fpu_op, bus.fpu_rmode}), 32'({m_op, m_rm}));
    chk("fpu_opa", bus.fpu_opa, m_a);
    chk("fpu_opb", bus.fpu_opb, m_b);
`ifdef FPU_ARB_STICKY_EN
    chk("sticky", 32'({bus.sticky1, bus.sticky0}), 32'({m_s1, m_s0}));
    m_s0 = bus.sticky0_clr ? 8'h00 : (m_s0 | set0);
    m_s1 = bus.sticky1_clr ? 8'h00 : (m_s1 | set1);
`endif
    // the requester holding priority is the one not served last
    pri = !m_last;
    r0 = 1'b0;
    r1 = 1'b0;
    if (m_state == M_RUN && en) begin
      if (pri ? bus.req1_valid : bus.req0_valid) begin
        if (pri) r1 = 1'b1; else r0 = 1'b1;
      end else if (pri ? bus.req0_valid : bus.req1_valid) begin
        if (pri) r0 = 1'b1; else r1 = 1'b1;
      end
    end
    chk("ready", 32'({bus.req1_ready, bus.req0_ready}), 32'({r1, r0}));
    if (bus.req0_valid && bus.req0_ready) acc_hist.push_back(0);
    if (bus.req1_valid && bus.req1_ready) acc_hist.push_back(1);
    a0 = bus.req0_valid && r0;
    a1 = bus.req1_valid && r1;
    fire = (q.size() != 0) && (q[0].due == cyc + 1);
    case (m_state)
      M_IDLE:  if (en) m_state = M_RUN;
      M_RUN:   if (!en) m_state = M_DRAIN;
      default: if (en) m_state = M_RUN; else if (m_cnt == 0) m_state = M_IDLE;
    endcase
    m_cnt = m_cnt + ((a0 || a1) ? 1 : 0) - (fire ? 1 : 0);
    if (a0 || a1) begin
      m_op = a1 ? bus.req1_op    : bus.req0_op;
      m_rm = a1 ? bus.req1_rmode : bus.req0_rmode;
      m_a  = a1 ? bus.req1_opa   : bus.req0_opa;
      m_b  = a1 ? bus.req1_opb   : bus.req0_opb;
      e.tag   = a1;
      e.data  = fpu_model(m_op, m_a, m_b);
      e.flags = m_b[7:0];
      e.due   = cyc + 1 + int'(LAT);
      q.push_back(e);
      m_last = a1;
    end
  endtask

  always @(negedge clk) mon_step();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [2:0] op, input logic [1:0] rm,
                       input logic [31:0] a, input logic [31:0] b);
    if (i == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_rmode = rm;
      bus.req0_opa = a;   bus.req0_opb = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_rmode = rm;
      bus.req1_opa = a;   bus.req1_opb = b;
    end
  endtask

  // present one request and hold it until its accept edge has passed
  task automatic send(input int i, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    bit done = 1'b0;
    drive(i, 1'b1, op, 2'd1, a, b);
    for (int t = 0; t < int'(TMO) && !done; t++) begin
      @(negedge clk);
      done = (i == 0) ? bus.req0_ready : bus.req1_ready;
      tick();
    end
    drive(i, 1'b0, op, 2'd1, a, b);
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit seen;
    rst_n = 1'b0;
    en    = 1'b0;
    drive(0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0);
`ifdef FPU_ARB_STICKY_EN
    bus.sticky0_clr = 1'b0;
    bus.sticky1_clr = 1'b0;
`endif
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("idle_before_en", 32'(idle), 32'd1);
    en = 1'b1;
    repeat (2) tick();

    // single add from requester 0
    send(0, 3'd0, 32'h3F80_0000, 32'h4000_0000);
    chk("launch_opa", bus.fpu_opa, 32'h3F80_0000);
    repeat (LAT + 2) tick();
    chk("add_result", bus.rsp0_data, 32'h4040_0000);

    // serve requester 1 so the tie burst starts with requester 0
    send(1, 3'd3, 32'h0000_1234, 32'h0000_5678);
    repeat (LAT + 2) tick();
    base = rsp_seen;
    acc_hist.delete();
    drive(0, 1'b1, 3'd1, 2'd2, 32'hA5A5_0000, 32'h0000_0011);
    drive(1, 1'b1, 3'd2, 2'd3, 32'h5A5A_0000, 32'h0000_0022);
    repeat (6) tick();
    drive(0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0);
    chk("burst_accepts", 32'(acc_hist.size()), 32'd6);
    for (int i = 0; i < 6 && i < acc_hist.size(); i++)
      chk("burst_order", 32'(acc_hist[i]), 32'(i % 2));
    repeat (LAT + 3) tick();
    chk("burst_rsp_count", 32'(rsp_seen - base), 32'd6);

    // three accepts, then en drops while a request is still valid
    base = rsp_seen;
    drive(0, 1'b1, 3'd4, 2'd0, 32'h0BAD_F00D, 32'h0000_0040);
    repeat (3) tick();
    en = 1'b0;
    tick();
    chk("drain_idle_low", 32'(idle), 32'd0);
    chk("drain_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    drive(0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0);
    seen = 1'b0;
    for (int t = 0; t < int'(TMO) && !seen; t++) begin
      tick();
      seen = idle;
    end
    chk("drain_done_idle", 32'(idle), 32'd1);
    chk("drain_rsp_count", 32'(rsp_seen - base), 32'd3);

    // reset two cycles after an accept discards it
    en = 1'b1;
    repeat (2) tick();
    send(1, 3'd5, 32'hDEAD_0000, 32'h0000_0080);
    tick();
    base = rsp_seen;
    rst_n = 1'b0;
    #1;
    chk("async_rst_idle", 32'(idle), 32'd1);
    chk("async_rst_rsp1", bus.rsp1_data, 32'd0);
    chk("async_rst_opa", bus.fpu_opa, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (LAT + 4) tick();
    chk("rst_no_rsp", 32'(rsp_seen - base), 32'd0);

`ifdef FPU_ARB_STICKY_EN
    send(1, 3'd1, 32'h0000_1111, 32'h0000_0008);
    repeat (LAT + 2) tick();
    send(1, 3'd1, 32'h0000_2222, 32'h0000_0001);
    repeat (LAT + 2) tick();
    chk("sticky1_or", 32'(bus.sticky1), 32'h09);
    send(1, 3'd1, 32'h0000_3333, 32'h0000_0004);
    repeat (LAT) tick();
    bus.sticky1_clr = 1'b1;
    tick();
    bus.sticky1_clr = 1'b0;
    tick();
    chk("sticky1_clr", 32'(bus.sticky1), 32'h00);
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
